priority_grant_arbiter: RTL and testbench



---
 rtl/priority_grant_arbiter_pkg.sv | 24 ++
 rtl/priority_pick4.sv | 19 +
 rtl/priority_grant_arbiter.sv | 137 +++++++++++++
 tb/tb_priority_grant_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/priority_grant_arbiter_pkg.sv
// Shared definitions for the four-requester priority grant arbiter.
package priority_grant_arbiter_pkg;

   // Arbiter states. Encodings are fixed so they line up with the existing state decode.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StGap  = 2'b10
   } arb_state_e;

   // Requester indices. d is the highest priority.
   localparam logic [1:0] ReqA = 2'd0;
   localparam logic [1:0] ReqB = 2'd1;
   localparam logic [1:0] ReqC = 2'd2;
   localparam logic [1:0] ReqD = 2'd3;

   localparam int unsigned DefaultMaxHold = 8;

   // Expand a requester index into a one-hot grant vector.
   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/priority_pick4.sv
// Combinational 4-to-2 priority picker: bit 3 wins over bit 2, and so on down to bit 0.
module priority_pick4
   import priority_grant_arbiter_pkg::*;
(
   input  logic [3:0] vec,
   output logic [1:0] idx,
   output logic       any
);

   // Highest set bit wins; idx reads ReqA when nothing is set.
   always_comb begin
      any = |vec;
      idx = ReqA;
      if (vec[3])      idx = ReqD;
      else if (vec[2]) idx = ReqC;
      else if (vec[1]) idx = ReqB;
   end

endmodule

// File: rtl/priority_grant_arbiter.sv
// Fixed-priority arbiter for four requesters. A grant is held until the owner releases it or
// reaches the hold limit. An empty cycle always separates two consecutive owners.
module priority_grant_arbiter
   import priority_grant_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DefaultMaxHold,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   // MAX_HOLD == 2**CNT_W truncates to zero. The counter then wraps to zero on the last held
   // cycle, so the equality compare still fires at the right moment.
   localparam logic [CNT_W-1:0] MaxHoldT = CNT_W'(MAX_HOLD);

   arb_state_e       state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]       mask_q, mask_d;
   logic             mask_set;

   logic [3:0] elig;
   logic [1:0] elig_idx, req_idx, winner;
   logic       elig_any, req_any;

   assign elig = req & ~mask_q;

   priority_pick4 u_pick_elig (
      .vec (elig),
      .idx (elig_idx),
      .any (elig_any)
   );

   priority_pick4 u_pick_req (
      .vec (req),
      .idx (req_idx),
      .any (req_any)
   );

   // If everyone still requesting is masked, fall back to the raw requests so nobody starves.
   assign winner = elig_any ? elig_idx : req_idx;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      mask_set    = 1'b0;
      unique case (state_q)
         StIdle, StGap: begin
            if (req_any) begin
               state_d     = StBusy;
               gnt_d       = onehot4(winner);
               gnt_id_d    = winner;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = CNT_W'(1);
            end else begin
               state_d     = StIdle;
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
            end
         end
         StBusy: begin
            // A release in the limit cycle counts as a normal release, so it is checked first.
            if (!req[gnt_id_q] || hold_cnt_q == MaxHoldT) begin
               state_d     = StGap;
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               hold_cnt_d  = '0;
               if (req[gnt_id_q]) begin
                  timeout_d = 1'b1;
                  mask_set  = 1'b1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = StIdle;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // Mask update: set on forced release; a dropped request or a fully masked set clears it.
   always_comb begin
      mask_d = mask_q;
      if (mask_set) mask_d[gnt_id_q] = 1'b1;
      mask_d = mask_d & req;
      if (!elig_any && req_any) mask_d = '0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         mask_q      <= mask_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_grant_arbiter.sv
// Self-checking bench for priority_grant_arbiter (MAX_HOLD=8, CNT_W=4).
module tb_priority_grant_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic       to;
      string      name;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic       to;
      string      name;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   priority_grant_arbiter #(
      .MAX_HOLD (8),
      .CNT_W    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic [3:0] g);
      if (g[3]) return 2'd3;
      if (g[2]) return 2'd2;
      if (g[1]) return 2'd1;
      return 2'd0;
   endfunction

   function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                               input logic t, input string nm);
      vec_t v;
      v.rst = r; v.req = rq; v.gnt = g; v.to = t; v.name = nm;
      tbl.push_back(v);
   endfunction

   // Pop the oldest expectation and compare it against the registered outputs.
   task automatic check_out();
      exp_t e;
      logic [1:0] eid;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got gnt=%b with no expectation queued", gnt);
         return;
      end
      e   = exp_q.pop_front();
      eid = enc(e.gnt);
      if (gnt !== e.gnt || gnt_id !== eid || gnt_valid !== (|e.gnt) || timeout !== e.to) begin
         errors++;
         $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                  e.name, gnt, gnt_id, gnt_valid, timeout, e.gnt, eid, |e.gnt, e.to);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, and check it after the edge.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic t, input string nm);
      exp_t e;
      reset = r;
      req   = rq;
      e.gnt = g; e.to = t; e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      reset = 1'b1;
      req   = 4'b0000;

      // Reset with all requesting, then first grant goes to d.
      add(1, 4'b1111, 4'b0000, 0, "reset0");
      add(1, 4'b1111, 4'b0000, 0, "reset1");
      add(1, 4'b1111, 4'b0000, 0, "reset2");
      add(0, 4'b1111, 4'b1000, 0, "first_grant_d");
      add(0, 4'b0000, 4'b0000, 0, "d_release_gap");
      add(0, 4'b0000, 4'b0000, 0, "idle_after_d");
      // Lone a for three cycles.
      add(0, 4'b0001, 4'b0001, 0, "a_grant0");
      add(0, 4'b0001, 4'b0001, 0, "a_grant1");
      add(0, 4'b0001, 4'b0001, 0, "a_grant2");
      add(0, 4'b0000, 4'b0000, 0, "a_gap");
      add(0, 4'b0000, 4'b0000, 0, "a_idle");
      // b owns; d arrives but must wait for b's release and a GAP cycle.
      add(0, 4'b0010, 4'b0010, 0, "b_grant");
      add(0, 4'b1010, 4'b0010, 0, "b_no_preempt0");
      add(0, 4'b1010, 4'b0010, 0, "b_no_preempt1");
      add(0, 4'b1000, 4'b0000, 0, "b_release_gap");
      add(0, 4'b1000, 4'b1000, 0, "d_after_gap");
      add(0, 4'b0000, 4'b0000, 0, "d_release");
      add(0, 4'b0000, 4'b0000, 0, "idle_before_timeout");

      foreach (tbl[i]) step(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].to, tbl[i].name);

      // d and a both hog: d times out, a gets a turn, a times out, mask clears, d again.
      for (int i = 0; i < 8; i++) step(0, 4'b1001, 4'b1000, 0, "to_d_held");
      step(0, 4'b1001, 4'b0000, 1, "to_d_pulse");
      for (int i = 0; i < 8; i++) step(0, 4'b1001, 4'b0001, 0, "to_a_held");
      step(0, 4'b1001, 4'b0000, 1, "to_a_pulse");
      step(0, 4'b1001, 4'b1000, 0, "to_mask_clear_d");
      step(0, 4'b0000, 4'b0000, 0, "to_release");
      step(0, 4'b0000, 4'b0000, 0, "to_idle");

      // Lone hog c: 8 granted, 1 gap with timeout, repeat.
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 8; i++) step(0, 4'b0100, 4'b0100, 0, "hog_c_held");
         step(0, 4'b0100, 4'b0000, 1, "hog_c_pulse");
      end
      step(0, 4'b0100, 4'b0100, 0, "hog_c_regrant");
      step(0, 4'b0000, 4'b0000, 0, "hog_release");
      step(0, 4'b0000, 4'b0000, 0, "hog_idle");

      // Release lands exactly on the hold limit: normal release, no timeout.
      for (int i = 0; i < 8; i++) step(0, 4'b0001, 4'b0001, 0, "edge_a_held");
      step(0, 4'b0000, 4'b0000, 0, "edge_release_no_to");
      step(0, 4'b0001, 4'b0001, 0, "edge_regrant_a");
      step(0, 4'b0000, 4'b0000, 0, "edge_release2");
      step(0, 4'b0000, 4'b0000, 0, "edge_idle");

      // Build mask=1000, grant a up to hold_cnt=5, then reset: no gap, mask gone, d wins.
      for (int i = 0; i < 8; i++) step(0, 4'b1001, 4'b1000, 0, "rst_d_held");
      step(0, 4'b1001, 4'b0000, 1, "rst_d_pulse");
      for (int i = 0; i < 5; i++) step(0, 4'b1001, 4'b0001, 0, "rst_a_held");
      step(1, 4'b1001, 4'b0000, 0, "rst_mid_grant");
      step(0, 4'b1001, 4'b1000, 0, "rst_mask_cleared_d");
      step(0, 4'b0000, 4'b0000, 0, "rst_release");
      step(0, 4'b0000, 4'b0000, 0, "rst_idle");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: %0d expectations unchecked, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
